sargantana_icache_way_ctrl: RTL and testbench

//  Initiator side of one icache way SRAM (req/we/addr/data port). Accepts refill

---
 rtl/sargantana_icache_pkg.sv | 14 +
 rtl/sargantana_icache_line_assembler.sv | 59 +++++
 rtl/sargantana_icache_way_ctrl.sv | 122 ++++++++++++
 tb/tb_sargantana_icache_way_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared geometry and controller state encoding for the Sargantana icache way controller.
package sargantana_icache_pkg;

    localparam int SET_WIDHT  = 256;
    localparam int ADDR_WIDHT = 7;

    typedef enum logic [1:0] {
        SWEEP   = 2'd0,
        IDLE    = 2'd1,
        COLLECT = 2'd2,
        WRITE   = 2'd3
    } way_ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_line_assembler.sv
// Collects refill beats into one cache line, captures the set index on the first
// beat and flags refill_last mismatches against the beat count.
module sargantana_icache_line_assembler
    import sargantana_icache_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  i_accept,
    input  logic                  i_clear,
    input  logic [BEAT_W-1:0]     i_data,
    input  logic                  i_last,
    input  logic [ADDR_WIDHT-1:0] i_addr,
    output logic [SET_WIDHT-1:0]  o_line,
    output logic [ADDR_WIDHT-1:0] o_addr,
    output logic                  o_complete,
    output logic                  o_proto_err
);

    localparam int NBEATS = SET_WIDHT / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [CNT_W-1:0]      r_cnt;
    logic [SET_WIDHT-1:0]  r_line;
    logic [ADDR_WIDHT-1:0] r_addr;
    logic                  r_proto_err;
    logic                  w_final;
    logic                  w_take;

    assign w_final     = (r_cnt == CNT_W'(NBEATS - 1));
    assign w_take      = i_accept & ~i_clear;
    assign o_complete  = w_take & w_final;
    assign o_line      = r_line;
    assign o_addr      = r_addr;
    assign o_proto_err = r_proto_err;

    // NOTE: the line buffer is reset so a partial line from before reset can never be written.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt       <= '0;
            r_line      <= '0;
            r_addr      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_take & (i_last != w_final);
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_accept) begin
                r_line[int'(r_cnt) * BEAT_W +: BEAT_W] <= i_data;
                if (r_cnt == '0) begin
                    r_addr <= i_addr;
                end
                r_cnt <= w_final ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_way_ctrl.sv
// Write/read initiator for one icache way SRAM: line refill, lookup pass-through, flush sweep.
// Define SARGANTANA_ICACHE_WAY_INIT_EN to zero every set on leaving reset.
module sargantana_icache_way_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  lookup_req_i,
    input  logic [ADDR_WIDHT-1:0] lookup_addr_i,
    output logic                  lookup_gnt_o,
    input  logic                  refill_valid_i,
    output logic                  refill_ready_o,
    input  logic [ADDR_WIDHT-1:0] refill_addr_i,
    input  logic [BEAT_W-1:0]     refill_data_i,
    input  logic                  refill_last_i,
    input  logic                  flush_i,
    output logic                  way_req_o,
    output logic                  way_we_o,
    output logic [ADDR_WIDHT-1:0] way_addr_o,
    output logic [SET_WIDHT-1:0]  way_data_o,
    output logic                  refill_done_o,
    output logic                  proto_err_o,
    output logic                  busy_o
);

`ifdef SARGANTANA_ICACHE_WAY_INIT_EN
    localparam way_ctrl_state_t RESET_STATE = SWEEP;
`else
    localparam way_ctrl_state_t RESET_STATE = IDLE;
`endif

    localparam logic [ADDR_WIDHT-1:0] SWEEP_LAST = '1;

    way_ctrl_state_t       r_state;
    way_ctrl_state_t       w_next_state;
    logic [ADDR_WIDHT-1:0] r_sweep_cnt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_clear;
    logic                  w_line_complete;
    logic [SET_WIDHT-1:0]  w_line;
    logic [ADDR_WIDHT-1:0] w_line_addr;

    // Ready depends only on state, which keeps the beat handshake free of combinational loops.
    assign w_ready        = (r_state == IDLE) || (r_state == COLLECT);
    assign w_accept       = refill_valid_i & w_ready;
    assign w_clear        = flush_i & w_ready;
    assign refill_ready_o = w_ready;
    assign busy_o         = (r_state != IDLE);

    sargantana_icache_line_assembler #(
        .BEAT_W (BEAT_W)
    ) u_line_assembler (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .i_accept    (w_accept),
        .i_clear     (w_clear),
        .i_data      (refill_data_i),
        .i_last      (refill_last_i),
        .i_addr      (refill_addr_i),
        .o_line      (w_line),
        .o_addr      (w_line_addr),
        .o_complete  (w_line_complete),
        .o_proto_err (proto_err_o)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= RESET_STATE;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_sweep_cnt <= (r_state == SWEEP && !flush_i) ? r_sweep_cnt + 1'b1 : '0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        lookup_gnt_o  = 1'b0;
        way_req_o     = 1'b0;
        way_we_o      = 1'b0;
        way_addr_o    = '0;
        way_data_o    = '0;
        refill_done_o = 1'b0;
        unique case (r_state)
            IDLE, COLLECT: begin
                way_req_o    = lookup_req_i;
                way_addr_o   = lookup_addr_i;
                lookup_gnt_o = lookup_req_i;
                if (flush_i) begin
                    w_next_state = SWEEP;
                end else if (w_line_complete) begin
                    w_next_state = WRITE;
                end else if (w_accept) begin
                    w_next_state = COLLECT;
                end
            end
            WRITE: begin
                way_req_o     = 1'b1;
                way_we_o      = 1'b1;
                way_addr_o    = w_line_addr;
                way_data_o    = w_line;
                refill_done_o = 1'b1;
                w_next_state  = flush_i ? SWEEP : IDLE;
            end
            SWEEP: begin
                way_req_o  = 1'b1;
                way_we_o   = 1'b1;
                way_addr_o = r_sweep_cnt;
                if (!flush_i && r_sweep_cnt == SWEEP_LAST) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = RESET_STATE;
        endcase
    end

endmodule

// File: tb/tb_sargantana_icache_way_ctrl.sv
// Scoreboard bench for sargantana_icache_way_ctrl: expected way-port transactions are
// queued by the stimulus and checked by a negedge monitor whenever way_req_o is high.
module tb_sargantana_icache_way_ctrl;
    import sargantana_icache_pkg::*;

    localparam int AW = ADDR_WIDHT;
    localparam int SW = SET_WIDHT;
    localparam int BW = 64;
    localparam int NSETS = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          lookup_req_i;
    logic [AW-1:0] lookup_addr_i;
    logic          lookup_gnt_o;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [AW-1:0] refill_addr_i;
    logic [BW-1:0] refill_data_i;
    logic          refill_last_i;
    logic          flush_i;
    logic          way_req_o;
    logic          way_we_o;
    logic [AW-1:0] way_addr_o;
    logic [SW-1:0] way_data_o;
    logic          refill_done_o;
    logic          proto_err_o;
    logic          busy_o;

    sargantana_icache_way_ctrl #(.BEAT_W(BW)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .lookup_req_i   (lookup_req_i),
        .lookup_addr_i  (lookup_addr_i),
        .lookup_gnt_o   (lookup_gnt_o),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_addr_i  (refill_addr_i),
        .refill_data_i  (refill_data_i),
        .refill_last_i  (refill_last_i),
        .flush_i        (flush_i),
        .way_req_o      (way_req_o),
        .way_we_o       (way_we_o),
        .way_addr_o     (way_addr_o),
        .way_data_o     (way_data_o),
        .refill_done_o  (refill_done_o),
        .proto_err_o    (proto_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic          gnt;
        logic          done;
        logic          chk_data;
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_write(input logic [AW-1:0] addr, input logic [SW-1:0] data);
        exp_q.push_back('{we: 1'b1, gnt: 1'b0, done: 1'b1, chk_data: 1'b1, addr: addr, data: data});
    endtask

    task automatic push_read(input logic [AW-1:0] addr);
        exp_q.push_back('{we: 1'b0, gnt: 1'b1, done: 1'b0, chk_data: 1'b0, addr: addr, data: '0});
    endtask

    task automatic push_sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            exp_q.push_back('{we: 1'b1, gnt: 1'b0, done: 1'b0, chk_data: 1'b1, addr: AW'(i), data: '0});
        end
    endtask

    always @(negedge clk_i) begin
        if (rstn_i && way_req_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_way_req: we=%0b addr=%0h, expected no request", way_we_o, way_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("way_we", way_we_o, mon_e.we);
                check("way_addr", way_addr_o, mon_e.addr);
                check("lookup_gnt", lookup_gnt_o, mon_e.gnt);
                check("refill_done", refill_done_o, mon_e.done);
                if (mon_e.chk_data) check("way_data", way_data_o, mon_e.data);
            end
        end else if (rstn_i && refill_done_o) begin
            total++;
            bad++;
            $display("FAIL stray_refill_done: got 1 expected 0");
        end
    end

    // Drives nbeats beats; beat 0 carries the set index, later beats carry junk to prove it is ignored.
    task automatic send_line(input logic [AW-1:0] addr, input logic [SW-1:0] line, input int nbeats,
                             input logic [3:0] last_mask, input logic [3:0] err_mask);
        check("ready_before_line", refill_ready_o, 1'b1);
        if (nbeats == 4) push_write(addr, line);
        for (int k = 0; k < nbeats; k++) begin
            refill_valid_i = 1'b1;
            refill_addr_i  = (k == 0) ? addr : ~addr;
            refill_data_i  = line[k*BW +: BW];
            refill_last_i  = last_mask[k];
            @(posedge clk_i);
            #1;
            check($sformatf("proto_err_beat%0d", k), proto_err_o, err_mask[k]);
        end
        refill_valid_i = 1'b0;
        refill_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 400) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("idle_within_budget", busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [SW-1:0] line_a, line_b, line_c, line_d;

    initial begin
        line_a = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        line_b = {64'hdddd0000dddd0003, 64'hcccc0000cccc0002, 64'hbbbb0000bbbb0001, 64'haaaa0000aaaa0000};
        line_c = {64'h0f0f0f0f0f0f0f0f, 64'h8000000000000001, 64'hffffffffffffffff, 64'h0123456789abcdef};
        line_d = {64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};

        rstn_i = 1'b0; lookup_req_i = 1'b0; lookup_addr_i = '0; refill_valid_i = 1'b0;
        refill_addr_i = '0; refill_data_i = '0; refill_last_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_refill_done", refill_done_o, 1'b0);
        check("reset_proto_err", proto_err_o, 1'b0);
`ifdef SARGANTANA_ICACHE_WAY_INIT_EN
        push_sweep(NSETS - 1);
        rstn_i = 1'b1;
        check("init_sweep_busy", busy_o, 1'b1);
        check("init_sweep_not_ready", refill_ready_o, 1'b0);
        wait_idle();
`else
        check("reset_way_req", way_req_o, 1'b0);
        rstn_i = 1'b1;
        check("ready_after_reset", refill_ready_o, 1'b1);
        check("not_busy_after_reset", busy_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
`endif
        check("ready_when_idle", refill_ready_o, 1'b1);

        // Plain refill, with a lookup held across the WRITE cycle.
        send_line(7'h05, line_a, 4, 4'b1000, 4'b0000);
        lookup_req_i = 1'b1; lookup_addr_i = 7'h0A;
        push_read(7'h0A);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        lookup_req_i = 1'b0;

        // Early last on beat 1, then a line that never raises last.
        send_line(7'h20, line_b, 4, 4'b1010, 4'b0010);
        @(posedge clk_i);
        #1;
        send_line(7'h21, line_c, 4, 4'b0000, 4'b1000);
        @(posedge clk_i);
        #1;

        // Flush after two beats, then a second flush mid-sweep restarts the counter.
        send_line(7'h33, line_a, 2, 4'b0000, 4'b0000);
        flush_i = 1'b1;
        push_sweep(9);
        push_sweep(NSETS - 1);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("sweep_blocks_refill", refill_ready_o, 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        wait_idle();
        send_line(7'h33, line_d, 4, 4'b1000, 4'b0000);
        @(posedge clk_i);
        #1;

        // Reset in the middle of a line: nothing written, next line assembles from slot 0.
        send_line(7'h44, line_b, 2, 4'b0000, 4'b0000);
        rstn_i = 1'b0;
        #1;
        check("midreset_refill_done", refill_done_o, 1'b0);
        check("midreset_proto_err", proto_err_o, 1'b0);
        @(posedge clk_i);
        #1;
`ifdef SARGANTANA_ICACHE_WAY_INIT_EN
        push_sweep(NSETS - 1);
        rstn_i = 1'b1;
        wait_idle();
`else
        rstn_i = 1'b1;
        check("midreset_idle", busy_o, 1'b0);
`endif
        send_line(7'h44, line_c, 4, 4'b1000, 4'b0000);
        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", SW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
